// File: rtl/bcd_countdown_ctrl_pkg.sv
// Shared definitions for the two-digit BCD countdown timer controller.
package bcd_countdown_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Out-of-range front-panel digits saturate to 9 rather than wrapping.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_countdown_ctrl_tick_div.sv
// Prescaler producing a one-cycle count tick every TICK_DIV clocks while enabled.
module tick_div #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic mr,
   input  logic run,
   input  logic clr,
   output logic tick
);

   localparam int            CW       = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // tick must not depend on clr: the controller raises clr on the very tick that expires the count.
   assign tick = run && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge mr) begin
      if (!mr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// Two-digit BCD down-counting timer: load/run/pause/expire sequencing, digit borrow and alarm.
module bcd_countdown_ctrl
   import bcd_countdown_ctrl_pkg::*;
#(
   parameter int TICK_DIV    = 50000000,
   parameter int ALARM_TICKS = 3
) (
   input  logic       clk,
   input  logic       mr,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic [3:0] preset_tens,
   input  logic [3:0] preset_ones,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       busy,
   output logic       done,
   output logic       alarm,
   output logic [1:0] state
);

   localparam int            AW         = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
   localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

   state_e        state_q, state_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic [AW-1:0] acnt_q, acnt_d;
   logic          done_q, done_d;
   logic          run_s;
   logic          clr_s;
   logic          tick_s;

   assign run_s = (state_q == ST_RUN) || (state_q == ST_DONE);

   tick_div #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_div (
      .clk  (clk),
      .mr   (mr),
      .run  (run_s),
      .clr  (clr_s),
      .tick (tick_s)
   );

   // A tick coinciding with pause is still applied so no count is lost; expiry outranks pause.
   always_comb begin
      state_d = state_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      acnt_d  = acnt_q;
      clr_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               tens_d = bcd_clamp(preset_tens);
               ones_d = bcd_clamp(preset_ones);
            end else if (start) begin
               clr_s   = 1'b1;
               state_d = ((tens_q == 4'd0) && (ones_q == 4'd0)) ? ST_DONE : ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (tick_s) begin
               if (ones_q != 4'd0) begin
                  ones_d = ones_q - 4'd1;
               end else begin
                  ones_d = BCD_MAX;
                  tens_d = tens_q - 4'd1;
               end
            end else begin
               ones_d = ones_q;
            end
            if (tick_s && (tens_q == 4'd0) && (ones_q == 4'd1)) begin
               state_d = ST_DONE;
               clr_s   = 1'b1;
            end else if (pause) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (load) begin
               tens_d  = bcd_clamp(preset_tens);
               ones_d  = bcd_clamp(preset_ones);
               clr_s   = 1'b1;
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_DONE: begin
            if (load) begin
               tens_d  = bcd_clamp(preset_tens);
               ones_d  = bcd_clamp(preset_ones);
               acnt_d  = '0;
               clr_s   = 1'b1;
               state_d = ST_IDLE;
            end else if (tick_s) begin
               if (acnt_q == ALARM_LAST) begin
                  acnt_d  = '0;
                  tens_d  = 4'd0;
                  ones_d  = 4'd0;
                  state_d = ST_IDLE;
               end else begin
                  acnt_d = acnt_q + 1'b1;
               end
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign done_d = (state_d == ST_DONE) && (state_q != ST_DONE);

   always_ff @(posedge clk or negedge mr) begin
      if (!mr) begin
         state_q <= ST_IDLE;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         acnt_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         acnt_q  <= acnt_d;
         done_q  <= done_d;
      end
   end

   assign tens  = tens_q;
   assign ones  = ones_q;
   assign state = state_q;
   assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign alarm = (state_q == ST_DONE);
   assign done  = done_q;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Scoreboard bench for bcd_countdown_ctrl with TICK_DIV=4, ALARM_TICKS=2.
module tb_bcd_countdown_ctrl;

   logic       clk = 1'b0;
   logic       mr = 1'b1;
   logic       load = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] pt = 4'd0;
   logic [3:0] po = 4'd0;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       busy;
   logic       done;
   logic       alarm;
   logic [1:0] state;

   typedef struct {
      int          cyc;
      string       nm;
      logic [12:0] v;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   bcd_countdown_ctrl #(
      .TICK_DIV    (4),
      .ALARM_TICKS (2)
   ) dut (
      .clk         (clk),
      .mr          (mr),
      .load        (load),
      .start       (start),
      .pause       (pause),
      .preset_tens (pt),
      .preset_ones (po),
      .tens        (tens),
      .ones        (ones),
      .busy        (busy),
      .done        (done),
      .alarm       (alarm),
      .state       (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [12:0] pk(input logic [3:0] t, input logic [3:0] o,
                                      input logic [1:0] st, input logic b, input logic d,
                                      input logic a);
      return {t, o, st, b, d, a};
   endfunction

   function automatic void chk(input string nm, input logic [12:0] act, input logic [12:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got t=%0d o=%0d st=%0d busy=%b done=%b alarm=%b, want t=%0d o=%0d st=%0d busy=%b done=%b alarm=%b",
                  nm, act[12:9], act[8:5], act[4:3], act[2], act[1], act[0],
                  want[12:9], want[8:5], want[4:3], want[2], want[1], want[0]);
      end
   endfunction

   function automatic void flag(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: expectation not checked in time", nm);
   endfunction

   task automatic exp_at(input int at, input string nm, input logic [3:0] t, input logic [3:0] o,
                         input logic [1:0] st, input logic b, input logic d, input logic a);
      exp_t e;
      int   i;
      e.cyc = at;
      e.nm  = nm;
      e.v   = pk(t, o, st, b, d, a);
      i = sb.size();
      while (i > 0 && sb[i-1].cyc > at) i--;
      sb.insert(i, e);
   endtask

   task automatic pulse(input logic l, input logic s, input logic p, input logic [3:0] t,
                        input logic [3:0] o);
      load = l; start = s; pause = p; pt = t; po = o;
      @(negedge clk);
      load = 1'b0; start = 1'b0; pause = 1'b0;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.cyc < cyc) flag(mon_e.nm);
         else chk(mon_e.nm, pk(tens, ones, state, busy, done, alarm), mon_e.v);
      end
   end

   initial begin
      int n, s, r, t;
      #1 mr = 1'b0;
      #2 chk("reset", pk(tens, ones, state, busy, done, alarm), 13'd0);
      @(negedge clk);
      mr = 1'b1;
      @(negedge clk);

      // 1: 12 -> 11 -> 10 -> 09
      n = cyc; exp_at(n + 1, "t1_load", 4'd1, 4'd2, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 4'd1, 4'd2);
      n = cyc; s = n + 1;
      exp_at(s,      "t1_run",  4'd1, 4'd2, 2'd1, 1'b1, 1'b0, 1'b0);
      exp_at(s + 3,  "t1_hold", 4'd1, 4'd2, 2'd1, 1'b1, 1'b0, 1'b0);
      exp_at(s + 4,  "t1_11",   4'd1, 4'd1, 2'd1, 1'b1, 1'b0, 1'b0);
      exp_at(s + 8,  "t1_10",   4'd1, 4'd0, 2'd1, 1'b1, 1'b0, 1'b0);
      exp_at(s + 12, "t1_09",   4'd0, 4'd9, 2'd1, 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      wait_n(12);
      exp_at(s + 13, "t1_pause", 4'd0, 4'd9, 2'd2, 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
      exp_at(s + 14, "t1_pload", 4'd0, 4'd2, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 4'd0, 4'd2);

      // 2: 02 -> 01 -> 00, DONE for 8 cycles
      n = cyc; s = n + 1;
      exp_at(s,      "t2_run",   4'd0, 4'd2, 2'd1, 1'b1, 1'b0, 1'b0);
      exp_at(s + 4,  "t2_01",    4'd0, 4'd1, 2'd1, 1'b1, 1'b0, 1'b0);
      exp_at(s + 8,  "t2_done",  4'd0, 4'd0, 2'd3, 1'b0, 1'b1, 1'b1);
      exp_at(s + 9,  "t2_done1", 4'd0, 4'd0, 2'd3, 1'b0, 1'b0, 1'b1);
      exp_at(s + 15, "t2_alarm", 4'd0, 4'd0, 2'd3, 1'b0, 1'b0, 1'b1);
      exp_at(s + 16, "t2_idle",  4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      wait_n(16);

      // 3: pause holds prescaler, resume decrements after 2 cycles
      n = cyc; exp_at(n + 1, "t3_load", 4'd0, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 4'd0, 4'd5);
      n = cyc; s = n + 1;
      exp_at(s, "t3_run", 4'd0, 4'd5, 2'd1, 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      wait_n(1);
      exp_at(s + 2,  "t3_pause", 4'd0, 4'd5, 2'd2, 1'b1, 1'b0, 1'b0);
      exp_at(s + 11, "t3_held",  4'd0, 4'd5, 2'd2, 1'b1, 1'b0, 1'b0);
      pause = 1'b1;
      wait_n(10);
      pause = 1'b0;
      n = cyc; r = n + 1;
      exp_at(r,     "t3_resume", 4'd0, 4'd5, 2'd1, 1'b1, 1'b0, 1'b0);
      exp_at(r + 1, "t3_r1",     4'd0, 4'd5, 2'd1, 1'b1, 1'b0, 1'b0);
      exp_at(r + 2, "t3_04",     4'd0, 4'd4, 2'd1, 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      wait_n(2);
      exp_at(r + 3, "t3_pause2", 4'd0, 4'd4, 2'd2, 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);

      // 4: clamp, and start from 00
      exp_at(r + 4, "t4_clamp_p", 4'd9, 4'd9, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 4'hF, 4'hA);
      exp_at(r + 5, "t4_clamp_i", 4'd9, 4'd9, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 4'hA, 4'hF);
      n = cyc; exp_at(n + 1, "t4_load00", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      n = cyc; s = n + 1;
      exp_at(s,     "t4_done",  4'd0, 4'd0, 2'd3, 1'b0, 1'b1, 1'b1);
      exp_at(s + 1, "t4_done1", 4'd0, 4'd0, 2'd3, 1'b0, 1'b0, 1'b1);
      exp_at(s + 7, "t4_alarm", 4'd0, 4'd0, 2'd3, 1'b0, 1'b0, 1'b1);
      exp_at(s + 8, "t4_idle",  4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      wait_n(8);

      // 5: load ignored in RUN, start+pause -> PAUSE, load aborts DONE
      n = cyc; exp_at(n + 1, "t5_load", 4'd3, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 4'd3, 4'd1);
      n = cyc; s = n + 1;
      exp_at(s,     "t5_run", 4'd3, 4'd1, 2'd1, 1'b1, 1'b0, 1'b0);
      exp_at(s + 4, "t5_30",  4'd3, 4'd0, 2'd1, 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      wait_n(4);
      exp_at(s + 5, "t5_noload", 4'd3, 4'd0, 2'd1, 1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 4'd7, 4'd7);
      wait_n(1);
      exp_at(s + 7, "t5_stpause", 4'd3, 4'd0, 2'd2, 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
      exp_at(s + 8, "t5_pload", 4'd0, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 4'd0, 4'd1);
      n = cyc; t = n + 1;
      exp_at(t,     "t5_run01", 4'd0, 4'd1, 2'd1, 1'b1, 1'b0, 1'b0);
      exp_at(t + 4, "t5_done",  4'd0, 4'd0, 2'd3, 1'b0, 1'b1, 1'b1);
      exp_at(t + 5, "t5_done1", 4'd0, 4'd0, 2'd3, 1'b0, 1'b0, 1'b1);
      pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      wait_n(5);
      exp_at(t + 6, "t5_abort", 4'd7, 4'd7, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 4'd7, 4'd7);

      // 6: asynchronous reset mid-RUN
      n = cyc; exp_at(n + 1, "t6_load", 4'd4, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 4'd4, 4'd5);
      n = cyc; s = n + 1;
      exp_at(s, "t6_run", 4'd4, 4'd5, 2'd1, 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      wait_n(2);
      #2 mr = 1'b0;
      #1 chk("t6_async_rst", pk(tens, ones, state, busy, done, alarm), 13'd0);
      @(negedge clk);
      mr = 1'b1;
      n = cyc;
      exp_at(n + 1, "t6_done",  4'd0, 4'd0, 2'd3, 1'b0, 1'b1, 1'b1);
      exp_at(n + 2, "t6_done1", 4'd0, 4'd0, 2'd3, 1'b0, 1'b0, 1'b1);
      exp_at(n + 9, "t6_idle",  4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      wait_n(8);

      for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) flag("drain");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
